// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and line/word constants,
// common to uart_rx and the companion transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    localparam int   UART_DATA_W   = 8;
    localparam logic UART_IDLE_LVL = 1'b1;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; both flops
// reset to RST_VAL so the synchronized line comes out of reset at idle.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8 data bits LSB first, mid-bit sampling, optional even parity.
// Define UART_RX_PARITY_EN to compile in the parity bit and parity check.
//
//   state    | meaning
//   ST_IDLE  | line idle, waiting for a 1->0 edge on the synchronized line
//   ST_START | counting to mid start bit; a 1 there is treated as a glitch
//   ST_DATA  | sampling 8 data bits, one per bit period
//   ST_PARITY| sampling the even-parity bit (parity build only)
//   ST_STOP  | sampling the stop bit, then reporting the frame
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   RX_in,
    input  logic                   enable_parity,
    output logic [UART_DATA_W-1:0] rx_data_8bit,
    output logic                   valid_out,
    output logic                   busy,
    output logic                   parity_err,
    output logic                   frame_err
);

    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_W - 1);

    logic                   w_rx_s;
    logic                   w_tc;
    uart_state_t            r_state;
    logic                   r_rx_prev;
    logic [CW-1:0]          r_cnt;
    logic [2:0]             r_bit_cnt;
    logic [UART_DATA_W-1:0] r_shift;
    logic [UART_DATA_W-1:0] r_data;
    logic                   r_valid;
    logic                   r_busy;
    logic                   r_ferr;
`ifdef UART_RX_PARITY_EN
    logic                   r_par_en;
    logic                   r_par_bad;
    logic                   r_perr;
`else
    logic                   w_unused_parity_sel;
    assign w_unused_parity_sel = enable_parity;
`endif

    uart_sync2 #(.RST_VAL(UART_IDLE_LVL)) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (RX_in),
        .o_q   (w_rx_s)
    );

    // Down-counter reaches zero exactly on each sample point
    assign w_tc = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_rx_prev <= UART_IDLE_LVL;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_ferr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_en  <= 1'b0;
            r_par_bad <= 1'b0;
            r_perr    <= 1'b0;
`endif
        end else begin
            r_rx_prev <= w_rx_s;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr    <= 1'b0;
`endif
            if (r_state != ST_IDLE) begin
                r_cnt <= r_cnt - 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (r_rx_prev && !w_rx_s) begin
                        r_state   <= ST_START;
                        r_cnt     <= CNT_HALF;
                        r_bit_cnt <= '0;
                        r_busy    <= 1'b1;
`ifdef UART_RX_PARITY_EN
                        r_par_en  <= enable_parity;
                        r_par_bad <= 1'b0;
`endif
                    end
                end
                ST_START: begin
                    if (w_tc) begin
                        if (!w_rx_s) begin
                            r_state <= ST_DATA;
                            r_cnt   <= CNT_BIT;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_tc) begin
                        r_shift   <= {w_rx_s, r_shift[UART_DATA_W-1:1]};
                        r_cnt     <= CNT_BIT;
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= r_par_en ? ST_PARITY : ST_STOP;
`else
                            r_state <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (w_tc) begin
                        r_par_bad <= ^{r_shift, w_rx_s};
                        r_cnt     <= CNT_BIT;
                        r_state   <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    // Leave at mid stop bit so a back-to-back start edge is seen
                    if (w_tc) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        if (w_rx_s) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            r_perr  <= r_par_bad;
`endif
                        end else begin
                            r_ferr <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data_8bit = r_data;
    assign valid_out    = r_valid;
    assign busy         = r_busy;
    assign frame_err    = r_ferr;
`ifdef UART_RX_PARITY_EN
    assign parity_err   = r_perr;
`else
    assign parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames,
// compared against a frame-level timing/result model.
module tb_uart_rx;

    localparam int CPB = 16;
    localparam int H   = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_BUILD = 1'b1;
`else
    localparam bit PAR_BUILD = 1'b0;
`endif

    typedef struct {
        int         cyc;
        bit         v;
        bit         pe;
        bit         fe;
        logic [7:0] d;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       RX_in;
    logic       enable_parity;
    logic [7:0] rx_data_8bit;
    logic       valid_out;
    logic       busy;
    logic       parity_err;
    logic       frame_err;

    int         cyc = 0;
    int         n_chk = 0;
    int         n_bad = 0;
    int         bfrom = 1;
    int         bto = 0;
    bit         mon_en = 1'b0;
    logic [7:0] exp_last = 8'h00;
    exp_t       exp_q[$];
    exp_t       e;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk           (clk),
        .reset         (reset),
        .RX_in         (RX_in),
        .enable_parity (enable_parity),
        .rx_data_8bit  (rx_data_8bit),
        .valid_out     (valid_out),
        .busy          (busy),
        .parity_err    (parity_err),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at cycle %0d", tag, got, want, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Line-level frame: start, data LSB first, optional parity, stop.
    // Result is pushed with the cycle it must appear on (start edge + 2 sync
    // + 1 edge-detect, then half a bit, then one bit per remaining field).
    task automatic send_frame(input logic [7:0] d, input bit en, input bit bad_par,
                              input bit stop_bit);
        logic [10:0] fr;
        int          nb;
        bit          p;
        logic        pbit;
        exp_t        x;
        p    = PAR_BUILD && en;
        pbit = (^d) ^ bad_par;
        enable_parity = en;
        if (p) begin
            fr = {stop_bit, pbit, d, 1'b0};
            nb = 11;
        end else begin
            fr = {1'b0, stop_bit, d, 1'b0};
            nb = 10;
        end
        x.cyc = cyc + 3 + H + (9 + int'(p)) * CPB;
        x.v   = stop_bit;
        x.fe  = !stop_bit;
        x.pe  = stop_bit && p && ((^d) ^ pbit);
        x.d   = d;
        exp_q.push_back(x);
        bfrom = cyc + 3;
        bto   = x.cyc - 1;
        for (int i = 0; i < nb; i++) begin
            RX_in = fr[i];
            if (i == 1) enable_parity = 1'($urandom_range(0, 1));
            wait_cyc(CPB);
        end
    endtask

    task automatic idle_bits(input int n);
        RX_in = 1'b1;
        wait_cyc(n * CPB);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy", busy, (cyc >= bfrom && cyc <= bto));
            if (valid_out || parity_err || frame_err) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", {valid_out, parity_err, frame_err}, 3'b000);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_cycle", cyc, e.cyc);
                    chk("valid_out", valid_out, e.v);
                    chk("parity_err", parity_err, e.pe);
                    chk("frame_err", frame_err, e.fe);
                    if (e.v) exp_last = e.d;
                    chk("rx_data", rx_data_8bit, exp_last);
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q.pop_front();
                chk("missed_pulse", 1'b0, 1'b1);
            end
        end
    end

    initial begin
        int start;
        RX_in         = 1'b1;
        enable_parity = 1'b0;
        reset         = 1'b1;
        wait_cyc(3);
        chk("rst_data", rx_data_8bit, 8'h00);
        chk("rst_valid", valid_out, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_perr", parity_err, 1'b0);
        chk("rst_ferr", frame_err, 1'b0);
        reset  = 1'b0;
        mon_en = 1'b1;
        idle_bits(2);

        send_frame(8'h62, 1'b0, 1'b0, 1'b1);
        idle_bits(1);

        send_frame(8'hCC, 1'b1, 1'b0, 1'b1);
        idle_bits(1);
        send_frame(8'hCC, 1'b1, 1'b1, 1'b1);
        idle_bits(1);

        // Framing error followed by a long break; only the later frame counts
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        RX_in = 1'b0;
        wait_cyc(40 * CPB);
        idle_bits(1);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        idle_bits(1);

        start = cyc;
        bfrom = start + 3;
        bto   = start + 3 + H - 1;
        RX_in = 1'b0;
        wait_cyc(4);
        idle_bits(2);

        send_frame(8'h01, 1'b0, 1'b0, 1'b1);
        send_frame(8'h80, 1'b0, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
        idle_bits(1);

        // Reset in the middle of data bit 3 of 0x55
        enable_parity = 1'b0;
        start = cyc;
        bfrom = start + 3;
        bto   = start + 100000;
        RX_in = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 3; i++) begin
            RX_in = 1'((8'h55 >> i) & 8'h01);
            wait_cyc(CPB);
        end
        RX_in = 1'b0;
        wait_cyc(H);
        reset = 1'b1;
        RX_in = 1'b1;
        bto   = cyc;
        wait_cyc(1);
        exp_last = 8'h00;
        chk("midrst_data", rx_data_8bit, 8'h00);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_pulses", {valid_out, parity_err, frame_err}, 3'b000);
        wait_cyc(1);
        reset = 1'b0;
        idle_bits(2);
        send_frame(8'h0F, 1'b0, 1'b0, 1'b1);
        idle_bits(1);

        for (int n = 0; n < 24; n++) begin
            logic [7:0] d;
            bit         en;
            bit         bp;
            bit         sb;
            int         gap;
            d   = 8'($urandom_range(0, 255));
            en  = 1'($urandom_range(0, 1));
            bp  = ($urandom_range(0, 3) == 0);
            sb  = ($urandom_range(0, 5) != 0);
            gap = $urandom_range(0, 2);
            send_frame(d, en, bp, sb);
            if (!sb && gap == 0) gap = 1;
            if (gap > 0) idle_bits(gap);
        end

        idle_bits(3);
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
